// File: rtl/riscv_instr_loader.sv
// Streams 32-bit program words into a picorv32 leaf as four {byte address, byte}
// config packets per word, sent over the leaf's BFT packet input.
module riscv_instr_loader #(
    parameter int PACKET_BITS   = 49,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int CFG_PORT      = 0,
    parameter int ADDR_BITS     = 24,
    parameter int CNT_BITS      = 16
) (
    input  logic                     clk_bft,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [CNT_BITS-1:0]      num_words,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    output logic                     busy,
    output logic                     done,
    input  logic [31:0]              din,
    input  logic                     val_in,
    output logic                     ready_upward,
    output logic [PACKET_BITS-1:0]   dout,
    output logic                     val_out,
    input  logic                     ready_downward,
    output logic [1:0]               state_dbg
);
    localparam int RSV_BITS = PACKET_BITS - NUM_LEAF_BITS - NUM_PORT_BITS - ADDR_BITS - 8;
    localparam logic [NUM_PORT_BITS-1:0] CFG_PORT_F = NUM_PORT_BITS'(CFG_PORT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state;
    logic [ADDR_BITS-1:0]     addr_q;
    logic [ADDR_BITS-1:0]     addr_inc;
    logic [CNT_BITS-1:0]      remaining;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [31:0]              word_q;
    logic [1:0]               idx;

    assign state_dbg = state;
    // Byte address wraps naturally at 2^ADDR_BITS.
    assign addr_inc  = addr_q + ADDR_BITS'(1);

    function automatic logic [PACKET_BITS-1:0] make_packet(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [ADDR_BITS-1:0]     a,
        input logic [7:0]               b
    );
        return {leaf, CFG_PORT_F, {RSV_BITS{1'b0}}, a, b};
    endfunction

    // Handshakes: a word moves when val_in & ready_upward at a clock edge; a packet
    // moves when val_out & ready_downward. Once val_out rises, dout holds until accepted.
    always_ff @(posedge clk_bft or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            ready_upward <= 1'b0;
            val_out      <= 1'b0;
            dout         <= '0;
            addr_q       <= '0;
            remaining    <= '0;
            leaf_q       <= '0;
            word_q       <= '0;
            idx          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q    <= base_addr;
                        remaining <= num_words;
                        leaf_q    <= dest_leaf;
                        busy      <= 1'b1;
                        if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= FETCH;
                            ready_upward <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (val_in && ready_upward) begin
                        word_q       <= din;
                        idx          <= 2'd0;
                        ready_upward <= 1'b0;
                        val_out      <= 1'b1;
                        dout         <= make_packet(leaf_q, addr_q, din[7:0]);
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (ready_downward) begin
                        addr_q <= addr_inc;
                        idx    <= idx + 2'd1;
                        // Shift so the next byte to send is always in word_q[15:8].
                        word_q <= {8'h00, word_q[31:8]};
                        if (idx == 2'd3) begin
                            val_out <= 1'b0;
                            if (remaining == CNT_BITS'(1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                remaining    <= remaining - CNT_BITS'(1);
                                state        <= FETCH;
                                ready_upward <= 1'b1;
                            end
                        end else begin
                            dout <= make_packet(leaf_q, addr_inc, word_q[15:8]);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_instr_loader.sv
// Bench for riscv_instr_loader: randomized loads compared against a packet-list model
// built from word list, base address and destination leaf.
module tb_riscv_instr_loader;
    logic        clk_bft = 1'b0;
    logic        resetn;
    logic        start;
    logic [23:0] base_addr;
    logic [15:0] num_words;
    logic [4:0]  dest_leaf;
    logic        busy;
    logic        done;
    logic [31:0] din;
    logic        val_in;
    logic        ready_upward;
    logic [48:0] dout;
    logic        val_out;
    logic        ready_downward;
    logic [1:0]  state_dbg;

    always #5 clk_bft = ~clk_bft;

    riscv_instr_loader dut (
        .clk_bft(clk_bft), .resetn(resetn), .start(start), .base_addr(base_addr),
        .num_words(num_words), .dest_leaf(dest_leaf), .busy(busy), .done(done),
        .din(din), .val_in(val_in), .ready_upward(ready_upward), .dout(dout),
        .val_out(val_out), .ready_downward(ready_downward), .state_dbg(state_dbg)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] words[$];
    logic [48:0] exp_q[$];
    logic [48:0] got_q[$];
    int done_cnt, done_cyc, last_acc, stall_err, busy_cnt, timed_out;

    // Model: every word becomes four packets, byte b of word w at base + 4w + b (mod 2^24).
    task automatic build_expected(input logic [23:0] base, input int n, input logic [4:0] dest);
        exp_q.delete();
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [23:0] a;
                logic [31:0] wd;
                a  = base + 24'(4 * w + b);
                wd = words[w];
                exp_q.push_back({dest, 4'h0, 8'h00, a, wd[8*b +: 8]});
            end
        end
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Runs one load; records accepted packets and timing. Stops at idle after done,
    // after max_acc accepts (if >= 0), or at the cycle budget.
    task automatic drive_load(input logic [23:0] base, input int n, input logic [4:0] dest,
                              input int rd_pct, input int vin_pct, input int max_acc,
                              input int restart_at);
        int cyc;
        int widx;
        logic prev_stall;
        logic [48:0] prev_dout;
        logic rd;
        cyc = 0; widx = 0; prev_stall = 1'b0; prev_dout = '0;
        got_q.delete();
        done_cnt = 0; done_cyc = -1; last_acc = -1; stall_err = 0; busy_cnt = 0; timed_out = 0;
        @(negedge clk_bft);
        start = 1'b1; base_addr = base; num_words = 16'(n); dest_leaf = dest;
        @(negedge clk_bft);
        start = 1'b0; base_addr = 24'($urandom); num_words = 16'($urandom); dest_leaf = 5'($urandom);
        while (cyc < 2000) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (prev_stall && (!val_out || dout !== prev_dout)) stall_err++;
            if (done_cyc >= 0 && !busy && !done) break;
            if (max_acc >= 0 && got_q.size() >= max_acc) begin
                ready_downward = 1'b0;
                val_in = 1'b0;
                return;
            end
            start = (cyc == restart_at);
            rd = ($urandom_range(99) < rd_pct);
            ready_downward = rd;
            if (val_out && rd) begin
                got_q.push_back(dout);
                last_acc = cyc;
            end
            prev_stall = val_out && !rd;
            prev_dout = dout;
            val_in = 1'b0;
            din = $urandom;
            if (ready_upward && widx < n && $urandom_range(99) < vin_pct) begin
                val_in = 1'b1;
                din = words[widx];
                widx++;
            end
            @(negedge clk_bft);
            cyc++;
        end
        start = 1'b0;
        val_in = 1'b0;
        ready_downward = 1'b0;
        if (cyc >= 2000) timed_out = 1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; dest_leaf = '0;
        din = '0; val_in = 1'b0; ready_downward = 1'b0;
        repeat (3) @(negedge clk_bft);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else n_pass++;
        n_total++; if (ready_upward !== 1'b0) $display("FAIL reset_ready_up: got %b exp 0", ready_upward); else n_pass++;
        n_total++; if (val_out !== 1'b0) $display("FAIL reset_val_out: got %b exp 0", val_out); else n_pass++;
        n_total++; if (dout !== 49'h0) $display("FAIL reset_dout: got %h exp 0", dout); else n_pass++;
        resetn = 1'b1;
        @(negedge clk_bft);
    endtask

    task automatic test_single_word();
        words.delete();
        words.push_back(32'hDDCCBBAA);
        build_expected(24'h000100, 1, 5'd7);
        drive_load(24'h000100, 1, 5'd7, 100, 100, -1, -1);
        n_total++; if (timed_out !== 0) $display("FAIL single_timeout: got %0d exp 0", timed_out); else n_pass++;
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL single_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL single_pkt%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (done_cyc !== last_acc + 1) $display("FAIL single_done_lat: got %0d exp %0d", done_cyc, last_acc + 1); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL single_done_cnt: got %0d exp 1", done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [23:0] base;
        logic [4:0]  dest;
        base = 24'($urandom);
        dest = 5'($urandom);
        fill_words(4);
        build_expected(base, 4, dest);
        drive_load(base, 4, dest, 100, 100, -1, -1);
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL b2b_pkt%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        // One fetch cycle plus four send cycles per word.
        n_total++; if (done_cyc !== 5 * 4) $display("FAIL b2b_done_cycle: got %0d exp %0d", done_cyc, 5 * 4); else n_pass++;
    endtask

    task automatic test_random_stall();
        logic [23:0] base;
        logic [4:0]  dest;
        logic [48:0] last_pkt;
        for (int r = 0; r < 3; r++) begin
            base = 24'($urandom);
            dest = 5'($urandom);
            fill_words(3);
            build_expected(base, 3, dest);
            drive_load(base, 3, dest, 50, 60, -1, -1);
            n_total++; if (timed_out !== 0) $display("FAIL stall_timeout%0d: got %0d exp 0", r, timed_out); else n_pass++;
            n_total++; if (got_q.size() !== 12) $display("FAIL stall_count%0d: got %0d exp 12", r, got_q.size()); else n_pass++;
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL stall_pkt%0d_%0d: got %h exp %h", r, i, got_q[i], exp_q[i]); else n_pass++;
            end
            n_total++; if (stall_err !== 0) $display("FAIL stall_hold%0d: got %0d exp 0", r, stall_err); else n_pass++;
            n_total++; if (done_cnt !== 1) $display("FAIL stall_done_cnt%0d: got %0d exp 1", r, done_cnt); else n_pass++;
            last_pkt = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 49'h0;
            n_total++; if (last_pkt[31:8] + 24'd1 !== base + 24'd12) $display("FAIL stall_end_addr%0d: got %h exp %h", r, last_pkt[31:8] + 24'd1, base + 24'd12); else n_pass++;
        end
    endtask

    task automatic test_addr_wrap();
        fill_words(1);
        build_expected(24'hFFFFFE, 1, 5'd19);
        drive_load(24'hFFFFFE, 1, 5'd19, 100, 100, -1, -1);
        n_total++; if (got_q.size() !== 4) $display("FAIL wrap_count: got %0d exp 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL wrap_pkt%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_zero_words();
        words.delete();
        drive_load(24'h000400, 0, 5'd3, 100, 100, -1, -1);
        n_total++; if (got_q.size() !== 0) $display("FAIL zero_count: got %0d exp 0", got_q.size()); else n_pass++;
        n_total++; if (busy_cnt !== 1) $display("FAIL zero_busy_cycles: got %0d exp 1", busy_cnt); else n_pass++;
        n_total++; if (done_cyc !== 0) $display("FAIL zero_done_cycle: got %0d exp 0", done_cyc); else n_pass++;
        n_total++; if (done_cnt !== 1) $display("FAIL zero_done_cnt: got %0d exp 1", done_cnt); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        fill_words(2);
        build_expected(24'h002000, 2, 5'd9);
        drive_load(24'h002000, 2, 5'd9, 100, 100, -1, 3);
        n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL restart_count: got %0d exp %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL restart_pkt%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (done_cnt !== 1) $display("FAIL restart_done_cnt: got %0d exp 1", done_cnt); else n_pass++;
        repeat (2) @(negedge clk_bft);
        n_total++; if (busy !== 1'b0) $display("FAIL restart_not_queued: got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int done_seen;
        fill_words(2);
        build_expected(24'h003000, 2, 5'd12);
        drive_load(24'h003000, 2, 5'd12, 100, 100, 2, -1);
        n_total++; if (val_out !== 1'b1 || dout !== exp_q[2]) $display("FAIL midrst_idx2: got %b/%h exp 1/%h", val_out, dout, exp_q[2]); else n_pass++;
        #2 resetn = 1'b0;
        #1;
        n_total++; if (val_out !== 1'b0) $display("FAIL midrst_val_out: got %b exp 0", val_out); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b exp 0", busy); else n_pass++;
        n_total++; if (dout !== 49'h0) $display("FAIL midrst_dout: got %h exp 0", dout); else n_pass++;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk_bft);
            if (done) done_seen++;
        end
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk_bft);
            if (done) done_seen++;
        end
        n_total++; if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d exp 0", done_seen); else n_pass++;
        fill_words(1);
        build_expected(24'h00ABC0, 1, 5'd30);
        drive_load(24'h00ABC0, 1, 5'd30, 100, 100, -1, -1);
        n_total++; if (got_q.size() !== 4) $display("FAIL midrst_reload_count: got %0d exp 4", got_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL midrst_reload_pkt%0d: got %h exp %h", i, got_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_random_stall();
        test_addr_wrap();
        test_zero_words();
        test_restart_ignored();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
